exe_stage: RTL and testbench

- Execute stage of the 5-stage ARM-subset pipeline. It consumes the registered ID/EX bundle and produces the registered EX/MEM bundle.
- Contains the Val2 generator (immediate rotate, register shift, memory offset), the ALU, and the architectural NZCV status register.
- Produces the branch target and branch-taken signals for the fetch stage.
- The status register output feeds back to the decode stage for condition evaluation.

---
 rtl/exe_stage_pkg.sv | 31 +++
 rtl/exe_stage_val2_gen.sv | 56 +++++
 rtl/exe_stage.sv | 162 ++++++++++++++++
 tb/tb_exe_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, shift types, NZCV bit positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package exe_stage_pkg;

    // exec_cmd encodings produced by decode
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    // Register-operand shift types, shift_operand[6:5]
    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    // Bit positions inside the 4-bit status register
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Operand-2 generator: rotated immediate, zero-extended memory offset, or shifted register.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports: val_rm (register operand), shift_operand (12-bit operand-2 field),
//        imm (I bit), is_mem (load/store offset select) -> val2.
module val2_gen
    import exe_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] val_rm,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              is_mem,
    output logic [DATA_W-1:0] val2
);

    logic [DATA_W-1:0]   imm_base;
    logic [4:0]          imm_rot;
    logic [4:0]          sh_amt;
    logic [2*DATA_W-1:0] imm_dbl;
    logic [2*DATA_W-1:0] rm_dbl;
    logic [DATA_W-1:0]   shifted;

    assign imm_base = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
    assign imm_rot  = {shift_operand[11:8], 1'b0};
    assign sh_amt   = shift_operand[11:7];

    // Rotate-right done by shifting a doubled copy; the low half is the result.
    assign imm_dbl = {imm_base, imm_base} >> imm_rot;
    assign rm_dbl  = {val_rm, val_rm} >> sh_amt;

    // An amount of zero leaves val_rm untouched for every type, ROR included.
    always_comb begin
        shifted = val_rm;
        case (shift_t'(shift_operand[6:5]))
            SH_LSL:  shifted = val_rm << sh_amt;
            SH_LSR:  shifted = val_rm >> sh_amt;
            SH_ASR:  shifted = $unsigned($signed(val_rm) >>> sh_amt);
            SH_ROR:  shifted = rm_dbl[DATA_W-1:0];
            default: shifted = val_rm;
        endcase
    end

    // Immediate wins over the memory offset; the offset is never shift-decoded.
    always_comb begin
        if (imm)
            val2 = imm_dbl[DATA_W-1:0];
        else if (is_mem)
            val2 = {{(DATA_W-12){1'b0}}, shift_operand};
        else
            val2 = shifted;
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand-2 generation, 33-bit ALU, NZCV register, branch target, EX/MEM register.
// Latency: one cycle to the EX/MEM outputs; branch_taken/branch_addr are combinational.
// Backpressure: none; a new ID/EX bundle is accepted every cycle, flushes arrive as bubbles.
//
// Ports: ID/EX control (wb_en_in, mem_r_in, mem_w_in, b_in, s_in), exec_cmd, pc_in,
//        val_rn, val_rm, imm, shift_operand, simm24, dest_in  ->  registered
//        wb_en, mem_r, mem_w, alu_res, st_val, dest; status (NZCV) to decode;
//        branch_taken, branch_addr to fetch.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_in,
    input  logic              mem_r_in,
    input  logic              mem_w_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [3:0]        exec_cmd,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [23:0]       simm24,
    input  logic [3:0]        dest_in,
    output logic              wb_en,
    output logic              mem_r,
    output logic              mem_w,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] st_val,
    output logic [3:0]        dest,
    output logic [3:0]        status,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr
);

    logic [DATA_W-1:0] val2;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    logic [3:0]        nzcv_next;
    logic              is_arith;
    logic              is_sub;
    logic              is_logic;
    logic              c_in;

    val2_gen #(
        .DATA_W (DATA_W)
    ) u_val2_gen (
        .val_rm        (val_rm),
        .shift_operand (shift_operand),
        .imm           (imm),
        .is_mem        (mem_r_in | mem_w_in),
        .val2          (val2)
    );

    assign c_in = status[FLAG_C];

    // Subtraction is Rn + ~Val2 + 1 (SBC: + C), so the carry-out is already NOT borrow.
    always_comb begin
        sum      = '0;
        res      = '0;
        is_arith = 1'b0;
        is_sub   = 1'b0;
        is_logic = 1'b0;
        case (exec_cmd)
            CMD_MOV: begin
                res      = val2;
                is_logic = 1'b1;
            end
            CMD_MVN: begin
                res      = ~val2;
                is_logic = 1'b1;
            end
            CMD_ADD: begin
                sum      = {1'b0, val_rn} + {1'b0, val2};
                is_arith = 1'b1;
            end
            CMD_ADC: begin
                sum      = {1'b0, val_rn} + {1'b0, val2} + {{DATA_W{1'b0}}, c_in};
                is_arith = 1'b1;
            end
            CMD_SUB: begin
                sum      = {1'b0, val_rn} + {1'b0, ~val2} + {{DATA_W{1'b0}}, 1'b1};
                is_arith = 1'b1;
                is_sub   = 1'b1;
            end
            CMD_SBC: begin
                sum      = {1'b0, val_rn} + {1'b0, ~val2} + {{DATA_W{1'b0}}, c_in};
                is_arith = 1'b1;
                is_sub   = 1'b1;
            end
            CMD_AND: begin
                res      = val_rn & val2;
                is_logic = 1'b1;
            end
            CMD_ORR: begin
                res      = val_rn | val2;
                is_logic = 1'b1;
            end
            CMD_EOR: begin
                res      = val_rn ^ val2;
                is_logic = 1'b1;
            end
            default: begin
                res = '0;
            end
        endcase
        if (is_arith)
            res = sum[DATA_W-1:0];
    end

    // Undefined opcodes leave every flag alone; logical ops leave C and V alone.
    always_comb begin
        nzcv_next = status;
        if (is_arith || is_logic) begin
            nzcv_next[FLAG_N] = res[DATA_W-1];
            nzcv_next[FLAG_Z] = (res == '0);
        end
        if (is_arith) begin
            nzcv_next[FLAG_C] = sum[DATA_W];
            if (is_sub)
                nzcv_next[FLAG_V] = (val_rn[DATA_W-1] != val2[DATA_W-1]) &&
                                    (res[DATA_W-1] != val_rn[DATA_W-1]);
            else
                nzcv_next[FLAG_V] = (val_rn[DATA_W-1] == val2[DATA_W-1]) &&
                                    (res[DATA_W-1] != val_rn[DATA_W-1]);
        end
    end

    // Branch resolution is independent of the status register.
    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{(DATA_W-26){simm24[23]}}, simm24, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en   <= 1'b0;
            mem_r   <= 1'b0;
            mem_w   <= 1'b0;
            alu_res <= '0;
            st_val  <= '0;
            dest    <= '0;
        end else begin
            wb_en   <= wb_en_in;
            mem_r   <= mem_r_in;
            mem_w   <= mem_w_in;
            alu_res <= res;
            st_val  <= val_rm;
            dest    <= dest_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            status <= 4'b0000;
        else if (s_in)
            status <= nzcv_next;
    end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_in, mem_w_in, b_in, s_in;
    logic [3:0]  exec_cmd;
    logic [31:0] pc_in, val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] simm24;
    logic [3:0]  dest_in;
    logic        wb_en, mem_r, mem_w;
    logic [31:0] alu_res, st_val;
    logic [3:0]  dest, status;
    logic        branch_taken;
    logic [31:0] branch_addr;

    int n_assert = 0;
    int n_fail   = 0;

    exe_stage #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_en_in      (wb_en_in),
        .mem_r_in      (mem_r_in),
        .mem_w_in      (mem_w_in),
        .b_in          (b_in),
        .s_in          (s_in),
        .exec_cmd      (exec_cmd),
        .pc_in         (pc_in),
        .val_rn        (val_rn),
        .val_rm        (val_rm),
        .imm           (imm),
        .shift_operand (shift_operand),
        .simm24        (simm24),
        .dest_in       (dest_in),
        .wb_en         (wb_en),
        .mem_r         (mem_r),
        .mem_w         (mem_w),
        .alu_res       (alu_res),
        .st_val        (st_val),
        .dest          (dest),
        .status        (status),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_en_in = 0; mem_r_in = 0; mem_w_in = 0; b_in = 0; s_in = 0;
        exec_cmd = 4'b0000; pc_in = 0; val_rn = 0; val_rm = 0;
        imm = 0; shift_operand = 0; simm24 = 0; dest_in = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        chk("rst_wb_en",   {31'b0, wb_en}, 32'h0);
        chk("rst_mem_r",   {31'b0, mem_r}, 32'h0);
        chk("rst_mem_w",   {31'b0, mem_w}, 32'h0);
        chk("rst_alu_res", alu_res,        32'h0);
        chk("rst_st_val",  st_val,         32'h0);
        chk("rst_dest",    {28'b0, dest},  32'h0);
        chk("rst_status",  {28'b0, status}, 32'h0);
        #10 rst = 1'b0;   // released between edges

        // ADD overflow: 0x7FFFFFFF + 1
        idle_inputs();
        exec_cmd = 4'b0010; val_rn = 32'h7FFF_FFFF; imm = 1; shift_operand = 12'h001;
        s_in = 1; wb_en_in = 1; dest_in = 4'd2;
        tick();
        chk("add_ovf_res",    alu_res,         32'h8000_0000);
        chk("add_ovf_status", {28'b0, status}, 32'h9);
        chk("add_ovf_wb_en",  {31'b0, wb_en},  32'h1);
        chk("add_ovf_dest",   {28'b0, dest},   32'h2);

        // SUB 5-5 -> Z and C (no borrow)
        idle_inputs();
        exec_cmd = 4'b0100; val_rn = 5; val_rm = 5; shift_operand = 12'h000;
        s_in = 1; wb_en_in = 1;
        tick();
        chk("sub_eq_res",    alu_res,         32'h0);
        chk("sub_eq_status", {28'b0, status}, 32'h6);

        // ADC 1+1+C without S: status holds
        idle_inputs();
        exec_cmd = 4'b0011; val_rn = 1; imm = 1; shift_operand = 12'h001; wb_en_in = 1;
        tick();
        chk("adc_res",    alu_res,         32'h3);
        chk("adc_status", {28'b0, status}, 32'h6);

        // MOV rotated immediate with S: N/Z from result, C/V kept (C=1,V=0)
        idle_inputs();
        exec_cmd = 4'b0001; imm = 1; shift_operand = 12'h4FF; s_in = 1; wb_en_in = 1;
        tick();
        chk("mov_imm_res",    alu_res,         32'hFF00_0000);
        chk("mov_imm_status", {28'b0, status}, 32'hA);

        // MOV ROR 1
        idle_inputs();
        exec_cmd = 4'b0001; val_rm = 32'h8000_0001; shift_operand = 12'h0E0; wb_en_in = 1;
        tick();
        chk("mov_ror_res", alu_res, 32'hC000_0000);

        // MOV ASR 4
        idle_inputs();
        exec_cmd = 4'b0001; val_rm = 32'h8000_0000; shift_operand = 12'h240; wb_en_in = 1;
        tick();
        chk("mov_asr_res", alu_res, 32'hF800_0000);

        // MOV LSR 8 and LSL 4 of register operand
        idle_inputs();
        exec_cmd = 4'b0001; val_rm = 32'h8000_00F0; shift_operand = 12'h420;
        tick();
        chk("mov_lsr_res", alu_res, 32'h0080_0000);
        exec_cmd = 4'b0001; val_rm = 32'h8000_00F1; shift_operand = 12'h200;
        tick();
        chk("mov_lsl_res", alu_res, 32'h0000_0F10);

        // LDR: offset zero-extended, no shift decode
        idle_inputs();
        exec_cmd = 4'b0010; mem_r_in = 1; wb_en_in = 1; val_rn = 32'h400;
        val_rm = 32'h1234_5678; shift_operand = 12'h804; dest_in = 4'd7;
        tick();
        chk("ldr_addr",  alu_res,        32'h0000_0C04);
        chk("ldr_mem_r", {31'b0, mem_r}, 32'h1);
        chk("ldr_dest",  {28'b0, dest},  32'h7);
        chk("ldr_st_val", st_val,        32'h1234_5678);

        // STR
        idle_inputs();
        exec_cmd = 4'b0010; mem_w_in = 1; val_rn = 32'h100; val_rm = 32'hCAFE_F00D;
        shift_operand = 12'h010;
        tick();
        chk("str_addr",   alu_res,        32'h0000_0110);
        chk("str_mem_w",  {31'b0, mem_w}, 32'h1);
        chk("str_wb_en",  {31'b0, wb_en}, 32'h0);
        chk("str_st_val", st_val,         32'hCAFE_F00D);

        // Branch backwards by 8 bytes
        idle_inputs();
        exec_cmd = 4'b0010; pc_in = 32'h100; simm24 = 24'hFFFFFE; b_in = 1;
        #1;
        chk("br_taken", {31'b0, branch_taken}, 32'h1);
        chk("br_addr",  branch_addr,           32'h0000_00F8);
        tick();
        chk("br_status", {28'b0, status}, 32'hA);

        // Forward branch target
        pc_in = 32'h1000; simm24 = 24'h000010;
        #1;
        chk("br_fwd_addr", branch_addr, 32'h0000_1040);

        // Bubble
        idle_inputs();
        #1;
        chk("bubble_taken", {31'b0, branch_taken}, 32'h0);
        tick();
        chk("bubble_ctl",    {29'b0, wb_en, mem_r, mem_w}, 32'h0);
        chk("bubble_status", {28'b0, status},              32'hA);

        // CMP 3 - 10 (no writeback): negative, borrow
        idle_inputs();
        exec_cmd = 4'b0100; val_rn = 3; val_rm = 10; s_in = 1;
        tick();
        chk("cmp_status", {28'b0, status}, 32'h8);
        chk("cmp_wb_en",  {31'b0, wb_en},  32'h0);

        // SBC with C=0: 10 - 3 - 1
        idle_inputs();
        exec_cmd = 4'b0101; val_rn = 10; val_rm = 3; s_in = 1; wb_en_in = 1;
        tick();
        chk("sbc_c0_res",    alu_res,         32'h6);
        chk("sbc_c0_status", {28'b0, status}, 32'h2);

        // SBC with C=1: 10 - 3
        tick();
        chk("sbc_c1_res", alu_res, 32'h7);

        // Undefined opcode with S: result 0, flags untouched
        idle_inputs();
        exec_cmd = 4'b1111; val_rn = 32'hFFFF_FFFF; val_rm = 32'h1; s_in = 1;
        tick();
        chk("undef_res",    alu_res,         32'h0);
        chk("undef_status", {28'b0, status}, 32'h2);

        // Logical ops
        idle_inputs();
        exec_cmd = 4'b1000; val_rn = 32'hF0F0; val_rm = 32'hFF00;
        tick();
        chk("eor_res", alu_res, 32'h0000_0FF0);
        exec_cmd = 4'b0111;
        tick();
        chk("orr_res", alu_res, 32'h0000_FFF0);
        exec_cmd = 4'b1001; imm = 1; shift_operand = 12'h000;
        tick();
        chk("mvn_res", alu_res, 32'hFFFF_FFFF);
        // TST with zero result: Z set, C kept at 1
        idle_inputs();
        exec_cmd = 4'b0110; val_rn = 32'hF0; val_rm = 32'h0F; s_in = 1;
        tick();
        chk("tst_res",    alu_res,         32'h0);
        chk("tst_status", {28'b0, status}, 32'h6);

        // Build status 0111 and wb_en=1, then reset mid-cycle
        idle_inputs();
        exec_cmd = 4'b0010; val_rn = 32'h8000_0000; imm = 1; shift_operand = 12'h102;
        s_in = 1; wb_en_in = 1; dest_in = 4'd9; val_rm = 32'h55;
        tick();
        chk("pre_rst_status", {28'b0, status}, 32'h7);
        chk("pre_rst_wb_en",  {31'b0, wb_en},  32'h1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_ctl",     {29'b0, wb_en, mem_r, mem_w}, 32'h0);
        chk("mid_rst_status",  {28'b0, status},              32'h0);
        chk("mid_rst_dest",    {28'b0, dest},                32'h0);
        chk("mid_rst_st_val",  st_val,                       32'h0);
        #1 rst = 1'b0;
        idle_inputs();
        exec_cmd = 4'b0001; imm = 1; shift_operand = 12'h005; wb_en_in = 1; dest_in = 4'd3;
        #1;
        chk("post_rel_hold", alu_res, 32'h0);
        tick();
        chk("post_rel_res",  alu_res,        32'h5);
        chk("post_rel_dest", {28'b0, dest},  32'h3);
        chk("post_rel_wb",   {31'b0, wb_en}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
